// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS instruction/data memory subsystem.
//   mem_state_t : data-read FSM states (IDLE -> WAIT -> RESP)
//   word_t      : 32-bit memory word
//   LOAD_SEL_*  : preload target select encoding
//   word_idx()  : byte address -> word index (addr[31:2])
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    typedef logic [31:0] word_t;

    localparam logic LOAD_SEL_IMEM = 1'b0;
    localparam logic LOAD_SEL_DMEM = 1'b1;

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/mips_mem_rd_pipe.sv
// Multi-cycle data-read sequencer: latency counter FSM plus registered rdata.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : a read request is present (and not overridden by a store)
//   hold       : freeze all state (preload in progress)
//   req_idx    : word index of the incoming request
//   lk_idx     : index the top must look up for us this cycle
//   lk_word    : looked-up word (OOR_RDATA already applied by the top)
//   ready      : response cycle
//   rdata      : registered read data
module mips_mem_rd_pipe
    import mips_mem_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic [29:0] req_idx,
    output logic [29:0] lk_idx,
    input  word_t       lk_word,
    output logic        ready,
    output word_t       rdata
);

    mem_state_t  state, state_nx;
    logic [2:0]  cnt;
    logic [29:0] cap_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cap_idx <= '0;
            rdata   <= '0;
        end else if (!hold) begin
            state <= state_nx;
            if (state == IDLE && start) begin
                cnt     <= 3'(RD_LATENCY - 1);
                cap_idx <= req_idx;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
            // Data is sampled on the edge that enters RESP; lk_idx already
            // points at the request index (IDLE) or the captured one (WAIT).
            if (state_nx == RESP)
                rdata <= lk_word;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (RD_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt <= 3'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == RESP);
        lk_idx = (state == IDLE) ? req_idx : cap_idx;
    end

endmodule

// File: rtl/mips_mem_subsys.sv
// Instruction + data memory subsystem for the simple MIPS CPU.
// Optional feature macro: MIPS_MEM_BYTE_EN (per-byte store enables).
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   imem_addr / imem_rdata       : combinational instruction fetch
//   dmem_addr/wdata/be/read/write: CPU data request
//   dmem_rdata / dmem_ready      : data response
//   load_valid/sel/addr/data     : preload port (full-word writes)
//   err_oor / err_proto          : sticky fault flags
module mips_mem_subsys
    import mips_mem_pkg::*;
#(
    parameter int    IMEM_WORDS = 64,
    parameter int    DMEM_WORDS = 64,
    parameter int    RD_LATENCY = 0,
    parameter word_t OOR_RDATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_be,
    input  logic        dmem_read,
    input  logic        dmem_write,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    input  logic        load_valid,
    input  logic        load_sel,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err_oor,
    output logic        err_proto
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    word_t imem [IMEM_WORDS];
    word_t dmem [DMEM_WORDS];

    logic [29:0] i_idx, d_idx, l_idx, lk_idx;
    logic        i_inr, d_inr, l_inr, lk_inr;
    logic        d_req, st_we, ld_ie, ld_de;
    logic [3:0]  be_eff;
    logic        be_fault;
    word_t       lk_word, pipe_rdata;
    logic        pipe_ready;

    assign i_idx = word_idx(imem_addr);
    assign d_idx = word_idx(dmem_addr);
    assign l_idx = word_idx(load_addr);

    assign i_inr = i_idx < 30'(IMEM_WORDS);
    assign d_inr = d_idx < 30'(DMEM_WORDS);
    assign l_inr = (load_sel == LOAD_SEL_IMEM) ? (l_idx < 30'(IMEM_WORDS))
                                                : (l_idx < 30'(DMEM_WORDS));

    assign imem_rdata = i_inr ? imem[i_idx[IAW-1:0]] : OOR_RDATA;

`ifdef MIPS_MEM_BYTE_EN
    assign be_eff   = dmem_be;
    assign be_fault = dmem_write && (dmem_be == 4'b0000);
`else
    assign be_eff   = 4'b1111;
    assign be_fault = 1'b0;
`endif

    assign d_req = dmem_read | dmem_write;
    // Preload owns the arrays while load_valid is high; CPU stores are dropped.
    assign st_we = dmem_write & ~load_valid & d_inr;
    assign ld_ie = load_valid & (load_sel == LOAD_SEL_IMEM) & l_inr;
    assign ld_de = load_valid & (load_sel == LOAD_SEL_DMEM) & l_inr;

    always_ff @(posedge clk) begin
        if (ld_ie)
            imem[l_idx[IAW-1:0]] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (st_we) begin
            for (int b = 0; b < 4; b++)
                if (be_eff[b])
                    dmem[d_idx[DAW-1:0]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
        if (ld_de)
            dmem[l_idx[DAW-1:0]] <= load_data;
    end

    // Shared read lookup: the request index for latency 0, otherwise whatever
    // index the read sequencer is tracking.
    assign lk_inr  = lk_idx < 30'(DMEM_WORDS);
    assign lk_word = lk_inr ? dmem[lk_idx[DAW-1:0]] : OOR_RDATA;

    generate
        if (RD_LATENCY > 0) begin : g_pipe
            mips_mem_rd_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (dmem_read & ~dmem_write),
                .hold    (load_valid),
                .req_idx (d_idx),
                .lk_idx  (lk_idx),
                .lk_word (lk_word),
                .ready   (pipe_ready),
                .rdata   (pipe_rdata)
            );
        end else begin : g_comb
            assign lk_idx     = d_idx;
            assign pipe_ready = 1'b0;
            assign pipe_rdata = '0;
        end
    endgenerate

    always_comb begin
        if (load_valid)           dmem_ready = 1'b0;
        else if (dmem_write)      dmem_ready = 1'b1;
        else if (RD_LATENCY == 0) dmem_ready = dmem_read;
        else                      dmem_ready = pipe_ready;
    end

    // Combinational reads read the array before the edge, so a same-cycle
    // store to the same word is not visible yet.
    assign dmem_rdata = (RD_LATENCY != 0) ? pipe_rdata
                      : (dmem_read & ~dmem_write & ~load_valid) ? lk_word : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oor   <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (!i_inr || (d_req && !d_inr) || (load_valid && !l_inr))
                err_oor <= 1'b1;
            if ((dmem_read && dmem_write) || (d_req && dmem_addr[1:0] != 2'b00) || be_fault)
                err_proto <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{imem_addr[1:0], load_addr[1:0], dmem_be};

endmodule

// File: doc/mips_mem_subsys.md
Name: mips_mem_subsys

Overview:
- Parametrised instruction + data memory subsystem for the simple MIPS CPU; replaces the ad-hoc bench arrays and raw index decode.
- Single instance sits between the CPU memory ports and the bench. It provides:
  - a combinational instruction fetch port;
  - a data port with configurable read latency and a ready handshake;
  - a preload port for programs and data;
  - sticky error flags for out-of-range and protocol faults.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of 2, >=2)
DMEM_WORDS, 64, data memory depth in 32-bit words (power of 2, >=2)
RD_LATENCY, 0, data read latency in cycles (0..7); 0 = combinational same-cycle read
OOR_RDATA, 32'h0000_0000, data returned for any out-of-range read (imem or dmem)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
imem_addr  input  32  byte address of fetch; word index = imem_addr[31:2]
imem_rdata  output  32  instruction word (combinational)
dmem_addr  input  32  byte address; word index = dmem_addr[31:2]
dmem_wdata  input  32  store data
dmem_be  input  4  byte enables (used only with MIPS_MEM_BYTE_EN)
dmem_read  input  1  load request (CPU memread_ctrl)
dmem_write  input  1  store request (CPU memwrite_ctrl)
dmem_rdata  output  32  load data, valid when dmem_ready & dmem_read
dmem_ready  output  1  request completes this cycle
load_valid  input  1  preload write strobe
load_sel  input  1  0 = imem, 1 = dmem
load_addr  input  32  preload byte address
load_data  input  32  preload word
err_oor  output  1  sticky: any access beyond depth
err_proto  output  1  sticky: dmem_read & dmem_write together, or misaligned dmem address

Behaviour:
- Reset (async, rst_n=0):
  - FSM -> IDLE; dmem_ready=0; dmem_rdata=0; err_oor=0; err_proto=0.
  - Memory arrays are NOT cleared.
  - imem_rdata stays combinational from the array.
- Address decode:
  - Word index = addr[31:2].
  - Out of range when index >= depth. Reads return OOR_RDATA; writes are dropped; err_oor sets.
  - dmem access with addr[1:0]!=0 sets err_proto; the access still proceeds using the word index.
- Instruction port: imem_rdata = mem[index] same cycle; no handshake.
- Writes (dmem_write=1):
  - Committed at the rising edge of the request cycle.
  - dmem_ready=1 combinationally in that cycle, for any RD_LATENCY.
- Reads with RD_LATENCY=0:
  - dmem_rdata = mem[index] combinationally.
  - dmem_ready=1 whenever dmem_read=1.
- Reads with RD_LATENCY=N>0, FSM IDLE -> WAIT -> RESP:
  - IDLE: on dmem_read, capture the word index, load the counter with N-1, go to WAIT (go directly to RESP if N=1). dmem_ready=0.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: dmem_rdata registered from the captured index; dmem_ready=1 for exactly one cycle; return to IDLE.
  - Ready therefore asserts N cycles after the request cycle.
  - The requester must hold dmem_read until ready. Address changes after capture are ignored.
  - A new read may be issued the cycle after RESP.
  - Dropping dmem_read mid-wait: the FSM still completes; the response is ignored by the CPU.
- Simultaneous dmem_read & dmem_write:
  - The write wins; the read is not started; err_proto sets.
- Preload port:
  - load_valid writes load_data to the memory selected by load_sel at the clock edge.
  - While load_valid=1: dmem_ready=0, CPU stores are blocked, and the FSM holds its state.
  - A preload to an out-of-range address sets err_oor.
- Same-cycle write/read to the same dmem word (RD_LATENCY=0): the read returns the old data.
- Reset mid-WAIT: the FSM aborts to IDLE; no response is issued.

Optional Feature:
- Macro: MIPS_MEM_BYTE_EN.
- Defined:
  - CPU stores update only the bytes whose dmem_be bit is set (be[0] = bits 7:0).
  - dmem_be==0 with dmem_write performs no update, still returns ready, and sets err_proto.
- Undefined:
  - dmem_be is ignored; every store writes the full word.
- Preload always writes full words in both cases.

Decomposition:
- Package mips_mem_pkg:
  - typedef enum {IDLE, WAIT, RESP} mem_state_t
  - typedef logic [31:0] word_t
  - constants LOAD_SEL_IMEM=0, LOAD_SEL_DMEM=1
  - function word_idx(addr)
- Sub-module mips_mem_rd_pipe: the latency counter/FSM plus registered rdata. It is instantiated only when RD_LATENCY>0 (generate); the top keeps the arrays and decode.

Test Plan:
- Preload imem[0..5] with the lw/lw/lw/add/j/sw program and dmem {1,5,5}; imem_addr=8 -> imem_rdata=instruction word 2 same cycle.
- RD_LATENCY=3, lw from dmem_addr=4 (value 5): the request is issued at cycle T, dmem_ready=1 with rdata=5 only at T+3, and stays 0 at T+1..T+2.
- Store 32'h0000_000A to dmem_addr=12, then read it back -> 32'hA, with ready in the store cycle.
- dmem_addr=DMEM_WORDS*4 read -> rdata=OOR_RDATA, err_oor=1, remaining high until reset.
- read and write together at addr 0 with wdata=7 -> mem[0]=7, no read response, err_proto=1.
- With MIPS_MEM_BYTE_EN: mem[1]=32'h11223344, store 32'hAABBCCDD with be=4'b0101 -> 32'h11BB33DD. Without the macro the result is 32'hAABBCCDD.
- Assert rst_n=0 during WAIT -> dmem_ready never pulses; the flags clear; the memory contents are retained.
